gate_truth_table_checker: RTL and testbench
===========================================

# gate_truth_table_checker

Synthesizable stimulus-and-response checker for any 2-input combinational gate in the basic logic gates library. On `start`, it drives the four input vectors 00, 01, 10, 11 onto the gate under test and samples the gate output `y` after each one. It assembles the observed 4-bit truth table, compares it with an expected table, and reports pass/fail with a per-vector mismatch mask. It sits beside a gate instance, the gate's inputs `a`/`b` driven by this block and its output `y` fed back, giving a hardware self-test for a gate.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before `y` is sampled; legal range 1..255.
- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  begin a sweep; accepted only in IDLE.
- `expected`  input  4  expected truth table; bit i is the expected `y` for vector i = {a,b}. Latched on the accepting edge.
- `y`  input  1  output of the gate under test.
- `a`  output  1  gate input a (registered).
- `b`  output  1  gate input b (registered).
- `busy`  output  1  high while a sweep is in progress.
- `done`  output  1  one-cycle pulse when results are valid.
- `pass`  output  1  1 if observed == expected; held until the next accepted start.
- `observed`  output  4  sampled truth table; bit i = `y` seen for vector i.
- `mismatch`  output  4  observed XOR expected; held until the next accepted start.

## Operation
- **Reset** (async, `rst_n` = 0): state IDLE. Every output is 0: `a`, `b`, `busy`, `done`, `pass`, `observed`, `mismatch`. The vector index and settle counter are 0.
- **Registers:** vector index `idx` (2 bits), settle counter `cnt` (8 bits), and `exp_q` (4 bits).
- **IDLE:**
  - `start` = 1 → latch `exp_q` = `expected`, clear `observed`, `mismatch` and `pass`, set `idx` = 0, `{a,b}` = 00, `cnt` = 0, `busy` = 1, go to DRIVE.
  - Otherwise hold.
- **DRIVE:**
  - `{a,b}` = `idx`; `cnt` increments every cycle.
  - At the edge where `cnt` == `SETTLE_CYCLES`-1: write `observed[idx]` = `y`, then:
    - `idx` < 3 → `idx`+1, `{a,b}` updated on this same edge, `cnt` = 0, stay in DRIVE.
    - `idx` == 3 → go to DONE, `busy` = 0, `done` = 1, `mismatch` = (`observed` with bit 3 = `y`) XOR `exp_q`, `pass` = (that value == 0).
- **DONE:** lasts exactly one cycle. `done` falls and the block returns to IDLE. `a`/`b` hold 11 until the next start.
- `start` is ignored in DRIVE and DONE. There is no queuing.
- `expected` changes after the accepting edge have no effect on the current sweep.
- `observed` bits fill progressively during a sweep. Unsampled bits read 0.

## Timing
- Accepting edge = E0. Vector i is driven from edge E0 + i·S, where S = `SETTLE_CYCLES`.
- Vector i is sampled at edge E0 + (i+1)·S, i.e. the last edge of its window. `y` therefore has at least S-1 full cycles plus one clock period to settle.
- `done` rises at E0 + 4·S and is high for exactly one cycle. `busy` is high from E0 to E0 + 4·S, covering 4·S cycles.
- Example with S = 2: samples at E0+2, E0+4, E0+6, E0+8; `done` is high for the cycle after E0+8.
- Earliest restart: `start` sampled at E0 + 4·S + 1, the first IDLE edge. A start held high during DONE is accepted on that edge.
- **Reset mid-sweep:** outputs clear immediately, without waiting for a clock. No `done` is produced. After `rst_n` deasserts, the first `start` runs a full fresh sweep.
- S = 1: each vector is held one cycle and sampled on the next edge, so the sweep takes 4 cycles.

## Test plan
1. NAND gate attached, `expected` = 4'b0111, S = 2 → `a`/`b` sequence 00, 01, 10, 11, each held 2 cycles; `done` pulses at E0+8; `observed` = 0111, `mismatch` = 0000, `pass` = 1.
2. NAND gate attached, `expected` = 4'b1000 (AND) → `observed` = 0111, `mismatch` = 1111, `pass` = 0.
3. `y` tied to 1, `expected` = 0111 → `observed` = 1111, `mismatch` = 1000, `pass` = 0.
4. `start` pulsed again at E0+3 and `expected` changed at E0+1 → both ignored; `done` still occurs once at E0+8 with the originally latched `exp_q`.
5. `rst_n` asserted at E0+5 → every output is 0 before the next edge; `done` never pulses; a start after release gives case 1 results.
6. S = 1, `start` held high continuously → sweeps back-to-back, `done` at E0+4, next accept at E0+5, second `done` at E0+9; `pass` = 1 both times.

Source files
------------

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker: sweeps a 2-input gate through 00,01,10,11,
// samples y after each settle window, and compares against an expected table.
// Ports: clk, rst_n (async low), start, expected[3:0], y (gate output) in;
//        a, b (gate inputs), busy, done, pass, observed[3:0], mismatch[3:0] out.
module gate_truth_table_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] expected,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] observed,
    output logic [3:0] mismatch
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] idx;
    logic [7:0] cnt;
    logic [3:0] exp_q;
    logic [3:0] obs_next;

    // Observed table including the sample taken on this edge, so the
    // final compare sees bit 3 without an extra cycle.
    always_comb begin
        obs_next      = observed;
        obs_next[idx] = y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= 2'd0;
            cnt      <= 8'd0;
            exp_q    <= 4'd0;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            observed <= 4'd0;
            mismatch <= 4'd0;
        end else begin
            case (state)
                S_DRIVE: begin
                    if (cnt == LAST_CNT) begin
                        observed <= obs_next;
                        cnt      <= 8'd0;
                        if (idx != 2'd3) begin
                            idx    <= idx + 2'd1;
                            {a, b} <= idx + 2'd1;
                        end else begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            mismatch <= obs_next ^ exp_q;
                            pass     <= (obs_next == exp_q);
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                // The cycle in which done is high ends on the first edge
                // that may accept a new sweep, so IDLE and DONE share it.
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        exp_q    <= expected;
                        observed <= 4'd0;
                        mismatch <= 4'd0;
                        pass     <= 1'b0;
                        idx      <= 2'd0;
                        cnt      <= 8'd0;
                        {a, b}   <= 2'b00;
                        busy     <= 1'b1;
                        state    <= S_DRIVE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb_gate_truth_table_checker: directed table-driven checks of the checker
// with S=2 and S=1 instances driving a modelled gate.
module tb_gate_truth_table_checker;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] expected = 4'd0;
    logic       y;
    logic       a, b, busy, done, pass;
    logic [3:0] observed, mismatch;
    logic [1:0] mode = 2'd0;

    logic       start1 = 1'b0;
    logic       y1;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] observed1, mismatch1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Gate model: 0 = NAND, 1 = tied high, 2 = tied low.
    always_comb begin
        case (mode)
            2'd0:    y = ~(a & b);
            2'd1:    y = 1'b1;
            default: y = 1'b0;
        endcase
    end

    assign y1 = ~(a1 & b1);

    gate_truth_table_checker #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
        .y(y), .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .observed(observed), .mismatch(mismatch)
    );

    gate_truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(4'b0111),
        .y(y1), .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .observed(observed1), .mismatch(mismatch1)
    );

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic [3:0] exp_in;
        logic [3:0] obs;
        logic [3:0] mis;
        logic       pass;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input vec_t v);
        mode     = v.mode;
        expected = v.exp_in;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk({v.name, " busy@E0"}, 32'(busy), 32'd1);
        chk({v.name, " ab@E0"}, 32'({a, b}), 32'd0);
        chk({v.name, " obs_clr"}, 32'(observed), 32'd0);
        for (int k = 1; k < 4 * S; k++) begin
            tick();
            chk({v.name, " ab_seq"}, 32'({a, b}), 32'(k / S));
            chk({v.name, " busy_seq"}, 32'({busy, done}), 32'b10);
        end
        tick();
        chk({v.name, " done"}, 32'({busy, done}), 32'b01);
        chk({v.name, " observed"}, 32'(observed), 32'(v.obs));
        chk({v.name, " mismatch"}, 32'(mismatch), 32'(v.mis));
        chk({v.name, " pass"}, 32'(pass), 32'(v.pass));
        chk({v.name, " ab_end"}, 32'({a, b}), 32'd3);
        tick();
        chk({v.name, " done_fall"}, 32'(done), 32'd0);
        chk({v.name, " hold"}, 32'({pass, mismatch}), 32'({v.pass, v.mis}));
    endtask

    vec_t vecs [5];
    vec_t nand_ok;

    initial begin
        int dcount;
        int dat;
        int d1;
        int d2;

        vecs[0] = '{"nand_ok",   2'd0, 4'b0111, 4'b0111, 4'b0000, 1'b1};
        vecs[1] = '{"nand_and",  2'd0, 4'b1000, 4'b0111, 4'b1111, 1'b0};
        vecs[2] = '{"tie1",      2'd1, 4'b0111, 4'b1111, 4'b1000, 1'b0};
        vecs[3] = '{"nand_xor",  2'd0, 4'b0110, 4'b0111, 4'b0001, 1'b0};
        vecs[4] = '{"tie0",      2'd2, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        nand_ok = vecs[0];

        #1;
        chk("reset_outs", 32'({a, b, busy, done, pass, observed, mismatch}),
            32'd0);
        chk("reset_outs1",
            32'({a1, b1, busy1, done1, pass1, observed1, mismatch1}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_hold", 32'({busy, done}), 32'd0);

        for (int i = 0; i < 5; i++) begin
            sweep(vecs[i]);
            tick();
        end

        // Restart and expected changes during a sweep are ignored.
        mode     = 2'd0;
        expected = 4'b0111;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dcount   = 0;
        dat      = -1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 1) expected = 4'b1000;
            if (e == 2) start = 1'b1;
            if (e == 3) start = 1'b0;
            tick();
            if (done) begin
                dcount++;
                dat = e;
                chk("ign pass", 32'(pass), 32'd1);
                chk("ign mismatch", 32'(mismatch), 32'd0);
            end
        end
        chk("ign done_cnt", 32'(dcount), 32'd1);
        chk("ign done_at", 32'(dat), 32'd8);
        chk("ign idle_after", 32'(busy), 32'd0);
        expected = 4'b0111;

        // Reset in the middle of a sweep.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs",
            32'({a, b, busy, done, pass, observed, mismatch}), 32'd0);
        dcount = 0;
        for (int e = 0; e < 12; e++) begin
            if (e == 2) rst_n = 1'b1;
            tick();
            if (done) dcount++;
        end
        chk("rst_mid_nodone", 32'(dcount), 32'd0);
        sweep(nand_ok);
        tick();

        // S=1 with start held high: back-to-back sweeps.
        start1 = 1'b1;
        tick();
        d1 = -1;
        d2 = -1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (done1) begin
                if (d1 < 0) d1 = e;
                else if (d2 < 0) d2 = e;
                chk("s1 pass", 32'(pass1), 32'd1);
                chk("s1 observed", 32'(observed1), 32'h7);
            end
            if (e == 5) begin
                chk("s1 reaccept", 32'({busy1, a1, b1}), 32'b100);
            end
        end
        start1 = 1'b0;
        chk("s1 done1_at", 32'(d1), 32'd4);
        chk("s1 done2_at", 32'(d2), 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule
